// File: rtl/execute.sv
// Y86 execute stage: ALU, condition-code register, branch/cmov condition and EX/MEM register.
// Optional feature: define EX_CMOV_EN to make icode 2 with ifun != 0 a conditional move.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_icode,
  input  logic [7:0]  ex_ifun,
  input  logic [31:0] ex_valA,
  input  logic [31:0] ex_valB,
  input  logic [31:0] ex_valC,
  input  logic [31:0] ex_valP,
  input  logic [7:0]  ex_dstE,
  input  logic [7:0]  ex_dstM,
  input  logic        stall,
  input  logic        bubble,
  input  logic        cc_inhibit,
  output logic [31:0] e_valE,
  output logic [7:0]  e_dstE,
  output logic        e_cnd,
  output logic [7:0]  mem_icode,
  output logic [7:0]  mem_ifun,
  output logic        mem_cnd,
  output logic [31:0] mem_valE,
  output logic [31:0] mem_valA,
  output logic [31:0] mem_valP,
  output logic [7:0]  mem_dstE,
  output logic [7:0]  mem_dstM,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam logic [7:0] RNONE    = 8'hF;
  localparam logic [7:0] I_NOP    = 8'h1;
  localparam logic [7:0] I_RRMOVL = 8'h2;
  localparam logic [7:0] I_IRMOVL = 8'h3;
  localparam logic [7:0] I_RMMOVL = 8'h4;
  localparam logic [7:0] I_MRMOVL = 8'h5;
  localparam logic [7:0] I_OPL    = 8'h6;
  localparam logic [7:0] I_JXX    = 8'h7;
  localparam logic [7:0] I_CALL   = 8'h8;
  localparam logic [7:0] I_RET    = 8'h9;
  localparam logic [7:0] I_PUSHL  = 8'hA;
  localparam logic [7:0] I_POPL   = 8'hB;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} aluFun_e;

  logic [31:0] aluA, aluB, aluOut;
  aluFun_e     aluFun;
  logic        zfNew, sfNew, ofNew;
  logic        cond;

  logic        ccZf_q, ccSf_q, ccOf_q;
  logic [7:0]  icode_q, ifun_q, dstE_q, dstM_q;
  logic        cnd_q;
  logic [31:0] valE_q, valA_q, valP_q;

  always_comb begin
    aluA = 32'h0;
    case (ex_icode)
      I_RRMOVL, I_OPL:           aluA = ex_valA;
      I_IRMOVL, I_RMMOVL,
      I_MRMOVL:                  aluA = ex_valC;
      I_CALL, I_PUSHL:           aluA = 32'hFFFF_FFFC;
      I_RET, I_POPL:             aluA = 32'h4;
      default:                   aluA = 32'h0;
    endcase
  end

  always_comb begin
    aluB = 32'h0;
    case (ex_icode)
      I_RMMOVL, I_MRMOVL, I_OPL, I_CALL,
      I_RET, I_PUSHL, I_POPL:    aluB = ex_valB;
      default:                   aluB = 32'h0;
    endcase
  end

  // Only OPl selects its ALU function; unknown ifun values fall back to add.
  always_comb begin
    aluFun = ALU_ADD;
    if (ex_icode == I_OPL) begin
      case (ex_ifun)
        8'h1:    aluFun = ALU_SUB;
        8'h2:    aluFun = ALU_AND;
        8'h3:    aluFun = ALU_XOR;
        default: aluFun = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    aluOut = 32'h0;
    ofNew  = 1'b0;
    case (aluFun)
      ALU_ADD: begin
        aluOut = aluB + aluA;
        ofNew  = (aluA[31] == aluB[31]) && (aluOut[31] != aluA[31]);
      end
      ALU_SUB: begin
        aluOut = aluB - aluA;
        ofNew  = (aluA[31] != aluB[31]) && (aluOut[31] != aluB[31]);
      end
      ALU_AND: aluOut = aluB & aluA;
      ALU_XOR: aluOut = aluB ^ aluA;
      default: aluOut = aluB + aluA;
    endcase
    zfNew = (aluOut == 32'h0);
    sfNew = aluOut[31];
  end

  // Conditions use the CC as it stands, before this cycle's OPl writes it.
  always_comb begin
    cond = 1'b0;
    case (ex_ifun)
      8'h0:    cond = 1'b1;
      8'h1:    cond = (ccSf_q ^ ccOf_q) | ccZf_q;
      8'h2:    cond = ccSf_q ^ ccOf_q;
      8'h3:    cond = ccZf_q;
      8'h4:    cond = !ccZf_q;
      8'h5:    cond = !(ccSf_q ^ ccOf_q);
      8'h6:    cond = !(ccSf_q ^ ccOf_q) && !ccZf_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    e_cnd = 1'b1;
    if (ex_icode == I_JXX) begin
      e_cnd = cond;
    end else if (ex_icode == I_RRMOVL) begin
`ifdef EX_CMOV_EN
      e_cnd = cond;
`else
      e_cnd = 1'b1;
`endif
    end
  end

  assign e_valE = aluOut;
  assign e_dstE = ((ex_icode == I_RRMOVL) && !e_cnd) ? RNONE : ex_dstE;

  // Bubble deliberately does not gate the CC write of the instruction in EX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ccZf_q <= 1'b1;
      ccSf_q <= 1'b0;
      ccOf_q <= 1'b0;
    end else if (!stall && (ex_icode == I_OPL) && !cc_inhibit) begin
      ccZf_q <= zfNew;
      ccSf_q <= sfNew;
      ccOf_q <= ofNew;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || (!stall && bubble)) begin
      icode_q <= I_NOP;
      ifun_q  <= 8'h0;
      cnd_q   <= 1'b1;
      valE_q  <= 32'h0;
      valA_q  <= 32'h0;
      valP_q  <= 32'h0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
    end else if (!stall) begin
      icode_q <= ex_icode;
      ifun_q  <= ex_ifun;
      cnd_q   <= e_cnd;
      valE_q  <= aluOut;
      valA_q  <= ex_valA;
      valP_q  <= ex_valP;
      dstE_q  <= e_dstE;
      dstM_q  <= ex_dstM;
    end
  end

  assign mem_icode = icode_q;
  assign mem_ifun  = ifun_q;
  assign mem_cnd   = cnd_q;
  assign mem_valE  = valE_q;
  assign mem_valA  = valA_q;
  assign mem_valP  = valP_q;
  assign mem_dstE  = dstE_q;
  assign mem_dstM  = dstM_q;
  assign cc_zf     = ccZf_q;
  assign cc_sf     = ccSf_q;
  assign cc_of     = ccOf_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the Y86 execute stage; expected EX/MEM + CC records go through a scoreboard queue.
// Build with or without EX_CMOV_EN; the cmov expectations follow the macro.
module tb_execute;

  typedef struct packed {
    logic [7:0]  icode;
    logic [7:0]  ifun;
    logic        cnd;
    logic [31:0] valE;
    logic [31:0] valA;
    logic [31:0] valP;
    logic [7:0]  dstE;
    logic [7:0]  dstM;
    logic        zf;
    logic        sf;
    logic        of;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_icode, ex_ifun, ex_dstE, ex_dstM;
  logic [31:0] ex_valA, ex_valB, ex_valC, ex_valP;
  logic        stall, bubble, cc_inhibit;
  logic [31:0] e_valE;
  logic [7:0]  e_dstE;
  logic        e_cnd;
  logic [7:0]  mem_icode, mem_ifun, mem_dstE, mem_dstM;
  logic        mem_cnd;
  logic [31:0] mem_valE, mem_valA, mem_valP;
  logic        cc_zf, cc_sf, cc_of;

  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];
  rec_t obsRec;
  rec_t expRec;
  rec_t lastRec;

  localparam rec_t RESET_REC = '{icode: 8'h1, ifun: 8'h0, cnd: 1'b1, valE: 32'h0, valA: 32'h0,
                                 valP: 32'h0, dstE: 8'hF, dstM: 8'hF, zf: 1'b1, sf: 1'b0, of: 1'b0};

  execute dut (
    .clk(clk), .rst(rst),
    .ex_icode(ex_icode), .ex_ifun(ex_ifun),
    .ex_valA(ex_valA), .ex_valB(ex_valB), .ex_valC(ex_valC), .ex_valP(ex_valP),
    .ex_dstE(ex_dstE), .ex_dstM(ex_dstM),
    .stall(stall), .bubble(bubble), .cc_inhibit(cc_inhibit),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .mem_icode(mem_icode), .mem_ifun(mem_ifun), .mem_cnd(mem_cnd),
    .mem_valE(mem_valE), .mem_valA(mem_valA), .mem_valP(mem_valP),
    .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  assign obsRec = '{icode: mem_icode, ifun: mem_ifun, cnd: mem_cnd, valE: mem_valE, valA: mem_valA,
                    valP: mem_valP, dstE: mem_dstE, dstM: mem_dstM, zf: cc_zf, sf: cc_sf, of: cc_of};

  task automatic drive(input logic [7:0] ic, input logic [7:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [31:0] p,
                       input logic [7:0] dE, input logic [7:0] dM);
    ex_icode = ic; ex_ifun = fn; ex_valA = a; ex_valB = b;
    ex_valC = c;   ex_valP = p; ex_dstE = dE; ex_dstM = dM;
  endtask

  // Advance one clock and pop the record the DUT should now be showing.
  task automatic stepPop(output rec_t e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: queue empty, got %h required a pending record", obsRec);
      e = obsRec;
    end else begin
      e = sb.pop_front();
    end
    lastRec = e;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; bubble = 1'b0; cc_inhibit = 1'b0;
    drive(8'h6, 8'h1, 32'h1, 32'h8000_0000, 32'h0, 32'h0, 8'h3, 8'hF);
    @(posedge clk);
    sb.push_back(RESET_REC);
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL reset: got %h required %h", obsRec, expRec);
    end
    rst = 1'b1;
  endtask

  task automatic test_subl_overflow();
    drive(8'h6, 8'h1, 32'h1, 32'h8000_0000, 32'h0, 32'h10, 8'h3, 8'hF);
    #1;
    checks++;
    if (e_valE !== 32'h7FFF_FFFF) begin
      errors++;
      $display("[TB] FAIL subl_e_valE: got %h required %h", e_valE, 32'h7FFF_FFFF);
    end
    sb.push_back('{8'h6, 8'h1, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h10, 8'h3, 8'hF, 1'b0, 1'b0, 1'b1});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL subl_overflow: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_branch();
    drive(8'h6, 8'h0, 32'h5, 32'hFFFF_FFFB, 32'h0, 32'h20, 8'h1, 8'hF);
    sb.push_back('{8'h6, 8'h0, 1'b1, 32'h0, 32'h5, 32'h20, 8'h1, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL addl_zero: got %h required %h", obsRec, expRec);
    end
    drive(8'h7, 8'h3, 32'h0, 32'h0, 32'h40, 32'h24, 8'hF, 8'hF);
    sb.push_back('{8'h7, 8'h3, 1'b1, 32'h0, 32'h0, 32'h24, 8'hF, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL je_taken: got %h required %h", obsRec, expRec);
    end
    drive(8'h7, 8'h4, 32'h0, 32'h0, 32'h40, 32'h28, 8'hF, 8'hF);
    sb.push_back('{8'h7, 8'h4, 1'b0, 32'h0, 32'h0, 32'h28, 8'hF, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL jne_not_taken: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_cmov();
    logic       expCnd;
    logic [7:0] expDst;
`ifdef EX_CMOV_EN
    expCnd = 1'b0; expDst = 8'hF;
`else
    expCnd = 1'b1; expDst = 8'h3;
`endif
    drive(8'h2, 8'h2, 32'h55, 32'h0, 32'h0, 32'h2C, 8'h3, 8'hF);
    #1;
    checks++;
    if (e_dstE !== expDst || e_cnd !== expCnd) begin
      errors++;
      $display("[TB] FAIL cmovl_taps: got dstE %h cnd %b required dstE %h cnd %b", e_dstE, e_cnd, expDst, expCnd);
    end
    sb.push_back('{8'h2, 8'h2, expCnd, 32'h55, 32'h55, 32'h2C, expDst, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL cmovl_reg: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_stack();
    drive(8'hA, 8'h0, 32'h77, 32'h100, 32'h0, 32'h30, 8'h4, 8'hF);
    sb.push_back('{8'hA, 8'h0, 1'b1, 32'hFC, 32'h77, 32'h30, 8'h4, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL pushl: got %h required %h", obsRec, expRec);
    end
    drive(8'hB, 8'h0, 32'h100, 32'h100, 32'h0, 32'h32, 8'h4, 8'h2);
    sb.push_back('{8'hB, 8'h0, 1'b1, 32'h104, 32'h100, 32'h32, 8'h4, 8'h2, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL popl: got %h required %h", obsRec, expRec);
    end
    drive(8'h3, 8'h0, 32'h0, 32'h999, 32'h1234, 32'h38, 8'h6, 8'hF);
    sb.push_back('{8'h3, 8'h0, 1'b1, 32'h1234, 32'h0, 32'h38, 8'h6, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL irmovl: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_cc_inhibit();
    cc_inhibit = 1'b1;
    drive(8'h6, 8'h0, 32'h1, 32'h1, 32'h0, 32'h3E, 8'h0, 8'hF);
    sb.push_back('{8'h6, 8'h0, 1'b1, 32'h2, 32'h1, 32'h3E, 8'h0, 8'hF, 1'b1, 1'b0, 1'b0});
    stepPop(expRec);
    cc_inhibit = 1'b0;
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL cc_inhibit: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_stall_bubble();
    rec_t held;
    held = lastRec;
    stall = 1'b1; bubble = 1'b1;
    drive(8'h6, 8'h1, 32'h1, 32'h8000_0000, 32'h0, 32'h44, 8'h3, 8'hF);
    sb.push_back(held);
    sb.push_back(held);
    stepPop(expRec);
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL stall_bubble_1: got %h required %h", obsRec, expRec);
    end
    stepPop(expRec);
    stall = 1'b0; bubble = 1'b0;
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL stall_bubble_2: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_bubble();
    bubble = 1'b1;
    drive(8'h6, 8'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h48, 8'h3, 8'hF);
    sb.push_back('{8'h1, 8'h0, 1'b1, 32'h0, 32'h0, 32'h0, 8'hF, 8'hF, 1'b0, 1'b1, 1'b1});
    stepPop(expRec);
    bubble = 1'b0;
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL bubble_nop: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_reset_stall();
    rst = 1'b0; stall = 1'b1; bubble = 1'b1;
    drive(8'h6, 8'h1, 32'h3, 32'h2, 32'h0, 32'h50, 8'h3, 8'h4);
    sb.push_back(RESET_REC);
    stepPop(expRec);
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    checks++;
    if (obsRec !== expRec) begin
      errors++;
      $display("[TB] FAIL reset_over_stall: got %h required %h", obsRec, expRec);
    end
  endtask

  task automatic test_back_to_back();
    // Each entry: OPl (ifun, A, B), then jXX ifun and its expected outcome on the new CC.
    logic [7:0]  opFun [4] = '{8'h1, 8'h3, 8'h2, 8'h1};
    logic [31:0] opA   [4] = '{32'h5, 32'hF0, 32'hFF00, 32'h5};
    logic [31:0] opB   [4] = '{32'h3, 32'hF0, 32'h0F0F, 32'h3};
    logic [31:0] opRes [4] = '{32'hFFFF_FFFE, 32'h0, 32'h0F00, 32'hFFFF_FFFE};
    logic [2:0]  opCc  [4] = '{3'b010, 3'b100, 3'b000, 3'b010};
    logic [7:0]  jFun  [4] = '{8'h2, 8'h3, 8'h1, 8'h5};
    logic        jCnd  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(8'h6, opFun[i], opA[i], opB[i], 32'h0, 32'h60 + 32'(i), 8'h2, 8'hF);
      sb.push_back('{8'h6, opFun[i], 1'b1, opRes[i], opA[i], 32'h60 + 32'(i), 8'h2, 8'hF,
                     opCc[i][2], opCc[i][1], opCc[i][0]});
      stepPop(expRec);
      checks++;
      if (obsRec !== expRec) begin
        errors++;
        $display("[TB] FAIL b2b_opl_%0d: got %h required %h", i, obsRec, expRec);
      end
      drive(8'h7, jFun[i], 32'h0, 32'h0, 32'h80, 32'h70 + 32'(i), 8'hF, 8'hF);
      #1;
      checks++;
      if (e_cnd !== jCnd[i]) begin
        errors++;
        $display("[TB] FAIL b2b_e_cnd_%0d: got %b required %b", i, e_cnd, jCnd[i]);
      end
      sb.push_back('{8'h7, jFun[i], jCnd[i], 32'h0, 32'h0, 32'h70 + 32'(i), 8'hF, 8'hF,
                     opCc[i][2], opCc[i][1], opCc[i][0]});
      stepPop(expRec);
      checks++;
      if (obsRec !== expRec) begin
        errors++;
        $display("[TB] FAIL b2b_jxx_%0d: got %h required %h", i, obsRec, expRec);
      end
    end
  endtask

  initial begin
    lastRec = RESET_REC;
    test_reset();
    test_subl_overflow();
    test_branch();
    test_cmov();
    test_stack();
    test_cc_inhibit();
    test_stall_bubble();
    test_bubble();
    test_reset_stall();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required %0d", sb.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the Y86 pipeline: consumes the decoded instruction held in the ID/EX register (`ex_*` signals), computes the ALU result, maintains the condition-code register, and evaluates branch/cmov conditions. It registers results into the EX/MEM pipeline register (`mem_*` outputs) with stall/bubble control. It also exposes combinational forwarding taps (`e_*`) to decode.

## Interface
- No parameters. Widths come from `defines.v`: `` `BYTE `` = 8 bits, `` `WORD `` = 32 bits. RNONE = 8'hF.
- `clk` — in — 1 — sole clock; all state updates on posedge.
- `rst` — in — 1 — synchronous, active-low reset; sampled on posedge clk.
- `ex_icode`, `ex_ifun` — in — 8 each — instruction code and function.
- `ex_valA`, `ex_valB`, `ex_valC`, `ex_valP` — in — 32 each — operands, constant, next PC.
- `ex_dstE`, `ex_dstM` — in — 8 each — destination register IDs.
- `stall` — in — 1 — hold the EX/MEM register and CC.
- `bubble` — in — 1 — load a nop into the EX/MEM register.
- `cc_inhibit` — in — 1 — suppress CC update; driven by hazard control on downstream exception.
- `e_valE` — out — 32 — combinational ALU result (forwarding).
- `e_dstE` — out — 8 — combinational effective dstE (forwarding).
- `e_cnd` — out — 1 — combinational condition result.
- `mem_icode`, `mem_ifun` — out — 8 each — registered.
- `mem_cnd` — out — 1 — registered.
- `mem_valE`, `mem_valA`, `mem_valP` — out — 32 each — registered.
- `mem_dstE`, `mem_dstM` — out — 8 each — registered.
- `cc_zf`, `cc_sf`, `cc_of` — out — 1 each — condition-code register.

## Operation
- aluA selection:
  - valA for icode 2 and 6.
  - valC for icode 3, 4, 5.
  - 32'hFFFFFFFC for icode 8 and A.
  - 32'h4 for icode 9 and B.
  - 0 otherwise.
- aluB selection:
  - valB for icode 4, 5, 6, 8, 9, A, B.
  - 0 otherwise.
- ALU function: ifun when icode == 6, else add. Functions:
  - 0: valE = B + A
  - 1: valE = B − A
  - 2: valE = B & A
  - 3: valE = B ^ A
  - Other ifun values are treated as add.
  - Arithmetic is modulo 2^32.
- CC computation:
  - ZF = (valE == 0); SF = valE[31].
  - OF for add = (A[31] == B[31]) && (valE[31] != A[31]).
  - OF for sub = (A[31] != B[31]) && (valE[31] != B[31]).
  - OF = 0 for and/xor.
- CC write: at posedge when rst = 1, icode == 6, !cc_inhibit, and !stall.
- Condition evaluation (uses current CC, i.e. values before this cycle's update):
  - ifun 0: 1
  - ifun 1 (le): (SF^OF) | ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF) & !ZF
  - other ifun: 0
- `e_cnd` is the condition result for icode 2 and 7, and 1 for all other icodes.
- `e_dstE` = RNONE when icode == 2 and !e_cnd; otherwise ex_dstE.
- EX/MEM register update, in priority order:
  - rst = 0: reset values.
  - else stall: hold all outputs.
  - else bubble: load a nop — icode 1, ifun 0, cnd 1, valE/valA/valP 0, dstE/dstM RNONE.
  - else: load icode, ifun, e_cnd, e_valE, ex_valA, ex_valP, e_dstE, ex_dstM.

## Timing
- Latency: EX/MEM outputs reflect `ex_*` one cycle after the posedge. The `e_*` taps are purely combinational.
- Reset values:
  - mem_icode = 1, mem_ifun = 0, mem_cnd = 1.
  - mem_valE / mem_valA / mem_valP = 0.
  - mem_dstE / mem_dstM = 8'hF.
  - cc_zf = 1, cc_sf = 0, cc_of = 0.
- Reset asserted mid-stream overrides stall and bubble in that cycle.
- Stall and bubble asserted together: stall wins, and the CC is also held.
- A bubble does not block a CC update by the instruction currently in EX.
- Back-to-back OPl: the second instruction's cnd/cmov sees the CC written by the first.

## Configuration
- `EX_CMOV_EN` defined: icode 2 with ifun ≠ 0 is a conditional move, evaluated as above.
- `EX_CMOV_EN` undefined:
  - icode 2 is always an unconditional rrmovl: e_cnd = 1 and e_dstE = ex_dstE regardless of ifun or CC.
  - jXX evaluation is unchanged.

## Test plan
- Reset: hold rst = 0 for 2 cycles → mem_icode = 1, mem_dstE = 8'hF, CC = {ZF 1, SF 0, OF 0}.
- subl overflow: OPl ifun 1, valA = 1, valB = 32'h80000000 → next cycle mem_valE = 32'h7FFFFFFF, CC = {ZF 0, SF 0, OF 1}.
- Taken branch:
  - addl valA = 5, valB = −5 → ZF = 1.
  - Then jXX ifun 3 → mem_cnd = 1.
  - Then jXX ifun 4 → mem_cnd = 0.
- cmovl not taken: CC {SF 0, OF 0}; icode 2 ifun 2, dstE = 3 → e_dstE = 8'hF and mem_dstE = 8'hF with `EX_CMOV_EN` defined; = 3 without it.
- Stack ops:
  - pushl valB = 32'h100 → mem_valE = 32'hFC.
  - popl valB = 32'h100 → mem_valE = 32'h104.
  - CC unchanged for both.
- Control:
  - OPl with cc_inhibit = 1 → CC unchanged.
  - stall = 1 and bubble = 1 → outputs held.
  - bubble only → nop loaded.
  - rst = 0 together with stall → reset values.
